yangmips_wb_ram_slave: RTL and testbench

Wishbone-classic data-memory responder for the yangMIPS minimal SOPC. It answers the CPU data-bus initiator with single-cycle-pulse acknowledges after a programmable number of wait states, and supports byte-lane writes and word reads. It sits on the SOPC data bus opposite the CPU's memory stage, replacing the zero-latency behavioural RAM so that stall paths get exercised.

---
 rtl/yangmips_wb_ram_slave.sv | 162 ++++++++++++++++
 tb/tb_yangmips_wb_ram_slave.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yangmips_wb_ram_slave.sv
// ---------------------------------------------------------------------------
// yangmips_wb_ram_slave
//
// Wishbone-classic data memory for the yangMIPS SOPC data bus. Each accepted
// request waits WAIT_STATES cycles and then answers with a one-cycle ack.
// Writes honour byte lanes. Reads always return the whole 32-bit word.
// This lets the CPU's memory-stage stall paths be exercised.
//
// Parameters
//   ADDR_WIDTH   word-address width; the memory holds 2^ADDR_WIDTH words
//   WAIT_STATES  cycles between request acceptance and ack (0..15)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   wb_cyc_i   bus cycle in progress
//   wb_stb_i   strobe; a request is valid when cyc and stb are both high
//   wb_we_i    1 = write, 0 = read
//   wb_adr_i   byte address; bits [ADDR_WIDTH+1:2] select the word
//   wb_sel_i   byte-lane enables
//   wb_dat_i   write data
//   wb_dat_o   registered read data, valid while wb_ack_o is high
//   wb_ack_o   registered one-cycle transfer acknowledge
// ---------------------------------------------------------------------------
module yangmips_wb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              waitCount_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              sel_q;
    logic [31:0]             dat_q;
    logic [31:0]             rdData_q;
    logic                    ack_q;

    logic [31:0]             mem_q [0:(2**ADDR_WIDTH)-1];

    logic                    request;
    logic                    accept;
    logic                    enterAck;
    logic                    txnWe;
    logic [ADDR_WIDTH-1:0]   txnIdx;
    logic [3:0]              txnSel;
    logic [31:0]             txnDat;

    // Address bits outside the word index are deliberately ignored, which
    // gives the modulo-depth aliasing.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

    assign request = wb_cyc_i & wb_stb_i;
    assign accept  = (state_q == S_IDLE) & request;

    // The edge that raises ack is either the accepting edge itself (no wait
    // states) or the WAIT edge where the counter has reached 1 with cyc
    // still asserted. Dropping cyc in WAIT aborts, so it never reaches ACK.
    assign enterAck = (accept & (WAIT_STATES == 0))
                    | ((state_q == S_WAIT) & wb_cyc_i & (waitCount_q == 4'd1));

    // With zero wait states the transfer completes on the accepting edge,
    // before the request has been latched, so the live bus is used there.
    always_comb begin
        txnWe  = we_q;
        txnIdx = idx_q;
        txnSel = sel_q;
        txnDat = dat_q;
        if (state_q == S_IDLE) begin
            txnWe  = wb_we_i;
            txnIdx = wb_adr_i[ADDR_WIDTH+1:2];
            txnSel = wb_sel_i;
            txnDat = wb_dat_i;
        end
    end

    // Control FSM with registered ack and read data. After ACK it always
    // returns to IDLE, so a held strobe is only re-sampled one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            waitCount_q <= 4'd0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            sel_q       <= 4'd0;
            dat_q       <= 32'h0;
            rdData_q    <= 32'h0;
            ack_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (request) begin
                        we_q        <= wb_we_i;
                        idx_q       <= wb_adr_i[ADDR_WIDTH+1:2];
                        sel_q       <= wb_sel_i;
                        dat_q       <= wb_dat_i;
                        waitCount_q <= WAIT_LOAD;
                        state_q     <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        waitCount_q <= 4'd0;
                        state_q     <= S_IDLE;
                    end else begin
                        waitCount_q <= waitCount_q - 4'd1;
                        if (waitCount_q == 4'd1) begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            ack_q <= enterAck;
            if (enterAck && !txnWe) begin
                rdData_q <= mem_q[txnIdx];
            end
        end
    end

    // Storage array has no reset; contents survive reset. The write is
    // gated by rst so a request presented while reset is held cannot land.
    always_ff @(posedge clk) begin
        if (rst && enterAck && txnWe) begin
            for (int b = 0; b < 4; b++) begin
                if (txnSel[b]) begin
                    mem_q[txnIdx][8*b +: 8] <= txnDat[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdData_q;
    assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_yangmips_wb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_yangmips_wb_ram_slave
//
// Four instances of the RAM slave with WAIT_STATES = 0, 1, 3 and 15 share
// one clock, reset and bus. Each instance has its own cyc line, so only the
// instance under test ever sees a request. A word-level memory model per
// instance predicts read data; latency is predicted as WAIT_STATES + 1
// cycles from the accepting edge to the edge that sees ack.
// ---------------------------------------------------------------------------
module tb_yangmips_wb_ram_slave;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NDUT  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat [NDUT];
    logic [3:0]  ack;

    int checks;
    int failures;

    logic [31:0] model [NDUT][DEPTH];

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : gDut
            localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
            yangmips_wb_ram_slave #(
                .ADDR_WIDTH (AW),
                .WAIT_STATES(WS)
            ) dut (
                .clk     (clk),
                .rst     (rst),
                .wb_cyc_i(cyc[g]),
                .wb_stb_i(stb),
                .wb_we_i (we),
                .wb_adr_i(adr),
                .wb_sel_i(sel),
                .wb_dat_i(wdat),
                .wb_dat_o(rdat[g]),
                .wb_ack_o(ack[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wsOf(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    // Word index a byte address lands on: drop the byte offset, wrap at depth.
    function automatic int wordOf(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    // Apply byte-lane enables as a full-word mask.
    function automatic logic [31:0] mergeLanes(input logic [31:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    // One bus transfer on instance k. Returns read data seen with ack, the
    // number of edges from acceptance to the ack-visible edge, whether ack
    // arrived within the budget, and ack one cycle later.
    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int lat,
                        output bit ok, output logic ackAfter);
        int n;
        @(negedge clk);
        cyc    = '0;
        cyc[k] = 1'b1;
        stb    = 1'b1;
        we     = w;
        adr    = a;
        sel    = s;
        wdat   = d;
        @(posedge clk);
        n  = 0;
        ok = 1'b0;
        rd = '0;
        while (n < 40) begin
            n++;
            #1;
            if (ack[k]) begin
                ok = 1'b1;
                rd = rdat[k];
                break;
            end
            @(posedge clk);
        end
        lat = n;
        cyc = '0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        ackAfter = ack[k];
    endtask

    task automatic test_reset();
        int first [NDUT];
        rst = 1'b0;
        cyc = 4'hF;
        stb = 1'b1;
        we  = 1'b0;
        adr = 32'h0;
        sel = 4'hF;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (ack[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL reset_hold dut%0d: ack=%b dat=%h required ack=0 dat=0",
                             k, ack[k], rdat[k]);
                end
            end
        end
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) first[k] = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NDUT; k++) begin
                if (first[k] == 0 && ack[k]) first[k] = n;
            end
        end
        cyc = '0;
        stb = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (first[k] != wsOf(k) + 1) begin
                failures++;
                $display("[TB] FAIL reset_first_ack dut%0d: latency=%0d required=%0d",
                         k, first[k], wsOf(k) + 1);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        xfer(1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, rd, lat, ok, after);
        model[1][wordOf(32'h10)] = 32'hDEADBEEF;
        checks++;
        if (!ok || lat != 2 || after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_latency: ok=%0d lat=%0d ackAfter=%b required ok=1 lat=2 ackAfter=0",
                     ok, lat, after);
        end
        xfer(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (!ok || lat != 2 || after !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL rd_deadbeef: ok=%0d lat=%0d ackAfter=%b data=%h required lat=2 data=deadbeef",
                     ok, lat, after, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        xfer(1, 1'b1, 32'h10, 4'hF, 32'h11223344, rd, lat, ok, after);
        model[1][wordOf(32'h10)] = 32'h11223344;
        xfer(1, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, rd, lat, ok, after);
        model[1][wordOf(32'h10)] = mergeLanes(model[1][wordOf(32'h10)], 32'hAABBCCDD, 4'b0101);
        xfer(1, 1'b0, 32'h10, 4'b0001, 32'h0, rd, lat, ok, after);
        checks++;
        if (!ok || rd !== 32'h11BB33DD) begin
            failures++;
            $display("[TB] FAIL byte_lanes: ok=%0d data=%h required 11bb33dd", ok, rd);
        end
        xfer(1, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, lat, ok, after);
        checks++;
        if (!ok || lat != 2) begin
            failures++;
            $display("[TB] FAIL sel_zero_ack: ok=%0d lat=%0d required ok=1 lat=2", ok, lat);
        end
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (!ok || rd !== model[1][wordOf(32'h10)]) begin
            failures++;
            $display("[TB] FAIL sel_zero_data: data=%h required %h", rd, model[1][wordOf(32'h10)]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        bit sawAck;
        xfer(2, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, rd, lat, ok, after);
        model[2][wordOf(32'h20)] = 32'h0BADF00D;
        @(negedge clk);
        cyc    = 4'b0100;
        stb    = 1'b1;
        we     = 1'b1;
        adr    = 32'h20;
        sel    = 4'hF;
        wdat   = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        cyc    = '0;
        stb    = 1'b0;
        sawAck = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack[2]) sawAck = 1'b1;
        end
        checks++;
        if (sawAck) begin
            failures++;
            $display("[TB] FAIL abort_no_ack: ack seen=1 required 0");
        end
        xfer(2, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (!ok || rd !== model[2][wordOf(32'h20)]) begin
            failures++;
            $display("[TB] FAIL abort_data: data=%h required %h", rd, model[2][wordOf(32'h20)]);
        end
    endtask

    task automatic test_sample_once();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        int n;
        xfer(2, 1'b1, 32'h30, 4'hF, 32'h01010101, rd, lat, ok, after);
        xfer(2, 1'b1, 32'h34, 4'hF, 32'h02020202, rd, lat, ok, after);
        model[2][wordOf(32'h30)] = 32'h01010101;
        model[2][wordOf(32'h34)] = 32'h02020202;
        @(negedge clk);
        cyc  = 4'b0100;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = 32'h30;
        sel  = 4'hF;
        wdat = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        we   = 1'b0;
        adr  = 32'h34;
        sel  = 4'b0001;
        wdat = 32'h0;
        n    = 1;
        ok   = 1'b0;
        while (n < 40 && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (ack[2]) ok = 1'b1;
        end
        cyc = '0;
        stb = 1'b0;
        model[2][wordOf(32'h30)] = 32'hCAFEF00D;
        checks++;
        if (!ok || n != 4) begin
            failures++;
            $display("[TB] FAIL sample_once_latency: ok=%0d lat=%0d required lat=4", ok, n);
        end
        @(posedge clk);
        xfer(2, 1'b0, 32'h30, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (rd !== model[2][wordOf(32'h30)]) begin
            failures++;
            $display("[TB] FAIL sample_once_target: data=%h required %h", rd, model[2][wordOf(32'h30)]);
        end
        xfer(2, 1'b0, 32'h34, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (rd !== model[2][wordOf(32'h34)]) begin
            failures++;
            $display("[TB] FAIL sample_once_other: data=%h required %h", rd, model[2][wordOf(32'h34)]);
        end
    endtask

    task automatic test_alias();
        logic [31:0] rd;
        logic [31:0] d;
        int lat;
        bit ok;
        logic after;
        for (int i = 0; i < 2; i++) begin
            int k;
            k = (i == 0) ? 0 : 3;
            d = $urandom;
            xfer(k, 1'b1, 32'h0000_1004, 4'hF, d, rd, lat, ok, after);
            model[k][wordOf(32'h1004)] = d;
            checks++;
            if (!ok || lat != wsOf(k) + 1 || after !== 1'b0) begin
                failures++;
                $display("[TB] FAIL alias_wr_latency dut%0d: lat=%0d ackAfter=%b required lat=%0d ackAfter=0",
                         k, lat, after, wsOf(k) + 1);
            end
            xfer(k, 1'b0, 32'h0000_0004, 4'hF, 32'h0, rd, lat, ok, after);
            checks++;
            if (!ok || lat != wsOf(k) + 1 || after !== 1'b0 || rd !== model[k][wordOf(32'h4)]) begin
                failures++;
                $display("[TB] FAIL alias_rd dut%0d: lat=%0d ackAfter=%b data=%h required lat=%0d data=%h",
                         k, lat, after, rd, wsOf(k) + 1, model[k][wordOf(32'h4)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        for (int k = 0; k < 3; k++) begin
            int t1;
            int t2;
            logic [31:0] d2;
            xfer(k, 1'b1, 32'h40, 4'hF, 32'h40404040 + k, rd, lat, ok, after);
            model[k][wordOf(32'h40)] = 32'h40404040 + k;
            @(negedge clk);
            cyc    = '0;
            cyc[k] = 1'b1;
            stb    = 1'b1;
            we     = 1'b0;
            adr    = 32'h40;
            sel    = 4'hF;
            t1     = -1;
            t2     = -1;
            d2     = '0;
            for (int n = 1; n <= 60; n++) begin
                @(posedge clk);
                #1;
                if (ack[k]) begin
                    if (t1 < 0) t1 = n;
                    else if (t2 < 0) begin
                        t2 = n;
                        d2 = rdat[k];
                    end
                end
                if (t2 >= 0) break;
            end
            cyc = '0;
            stb = 1'b0;
            checks++;
            if (t1 != wsOf(k) + 1 || t2 - t1 != wsOf(k) + 2 || d2 !== model[k][wordOf(32'h40)]) begin
                failures++;
                $display("[TB] FAIL back_to_back dut%0d: first=%0d spacing=%0d data=%h required first=%0d spacing=%0d data=%h",
                         k, t1, t2 - t1, d2, wsOf(k) + 1, wsOf(k) + 2, model[k][wordOf(32'h40)]);
            end
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        bit bad;
        xfer(3, 1'b1, 32'h50, 4'hF, 32'h13579BDF, rd, lat, ok, after);
        model[3][wordOf(32'h50)] = 32'h13579BDF;
        @(negedge clk);
        cyc  = 4'b1000;
        stb  = 1'b1;
        we   = 1'b1;
        adr  = 32'h50;
        sel  = 4'hF;
        wdat = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack[3] !== 1'b0 || rdat[3] !== 32'h0) bad = 1'b1;
        end
        cyc = '0;
        stb = 1'b0;
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ack[3]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_ack: ack or data seen during/after reset, required none");
        end
        xfer(3, 1'b0, 32'h50, 4'hF, 32'h0, rd, lat, ok, after);
        checks++;
        if (!ok || rd !== model[3][wordOf(32'h50)]) begin
            failures++;
            $display("[TB] FAIL reset_mid_wait_data: data=%h required %h", rd, model[3][wordOf(32'h50)]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        int lat;
        bit ok;
        logic after;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] d;
                d = $urandom;
                xfer(k, 1'b1, 32'(96 + 4 * i), 4'hF, d, rd, lat, ok, after);
                model[k][24 + i] = d;
            end
            for (int t = 0; t < 12; t++) begin
                logic [31:0] a;
                logic [31:0] d;
                logic [3:0] s;
                bit w;
                int idx;
                idx = 24 + int'($urandom_range(7, 0));
                a   = ($urandom & 32'hFFFF_F003) | 32'(idx * 4);
                d   = $urandom;
                s   = 4'($urandom);
                w   = 1'($urandom);
                xfer(k, w, a, s, d, rd, lat, ok, after);
                checks++;
                if (!ok || lat != wsOf(k) + 1 || after !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL random_timing dut%0d: ok=%0d lat=%0d ackAfter=%b required lat=%0d",
                             k, ok, lat, after, wsOf(k) + 1);
                end
                if (w) begin
                    model[k][wordOf(a)] = mergeLanes(model[k][wordOf(a)], d, s);
                end else begin
                    checks++;
                    if (rd !== model[k][wordOf(a)]) begin
                        failures++;
                        $display("[TB] FAIL random_read dut%0d adr=%h: data=%h required %h",
                                 k, a, rd, model[k][wordOf(a)]);
                    end
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        cyc      = '0;
        stb      = 1'b0;
        we       = 1'b0;
        adr      = '0;
        sel      = '0;
        wdat     = '0;
        #2;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_abort();
        test_sample_once();
        test_alias();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
